// File: rtl/pss8_pkg.sv
// Shared types and constants for the pss8 parallel-to-serial transmitter.
package pss8_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  localparam int unsigned DefWidth = 8;

  // Bit-counter width for a word of the given width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/pss8_if.sv
// Producer-side write port of pss8: word, write strobe and holding-register-empty flag.
interface pss8_if #(
  parameter int unsigned WIDTH = pss8_pkg::DefWidth
) ();

  logic             wr;
  logic [WIDTH-1:0] datai;
  logic             rdy;

  modport master (
    output wr,
    output datai,
    input  rdy
  );

  modport slave (
    input  wr,
    input  datai,
    output rdy
  );

endinterface

// File: rtl/pss8_shift.sv
// Shift register and bit counter; the presented bit comes straight from a flop.
module pss8_shift
  import pss8_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             advance,
  input  logic             clear,
  input  logic [WIDTH-1:0] data,
  output logic             cur_bit,
  output logic             last,
  output logic             penult
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  logic [WIDTH-1:0] sr_q;
  logic [CntW-1:0]  cnt_q;

  // Load a word, step one bit, or clear so the idle line reads 0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      sr_q  <= data;
      cnt_q <= '0;
    end else if (clear) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (advance) begin
      sr_q  <= MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign cur_bit = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
  assign last    = (cnt_q == CntW'(WIDTH - 1));
  // Next advance lands on the last bit; used to time the done pulse.
  assign penult  = (cnt_q == CntW'(WIDTH - 2));

endmodule

// File: rtl/pss8.sv
// pss8: parallel-to-serial transmitter with a one-word holding register.
module pss8
  import pss8_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic  clk,
  input  logic  clr,
  input  logic  start,
  pss8_if.slave bus,
  output logic  datao,
  output logic  frame,
  output logic  done
);

  state_e           state_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_valid_q;
  logic             frame_q;
  logic             done_q;

  logic load, advance, clear;
  logic cur_bit, last, penult;

  // Decide whether this edge loads a word, steps a bit, or ends the frame.
  // With start low on the last bit the frame ends; any queued word stays held.
  always_comb begin
    load    = 1'b0;
    advance = 1'b0;
    clear   = 1'b0;
    case (state_q)
      StIdle: begin
        load = hold_valid_q && start;
      end
      StShift: begin
        if (last) begin
          if (hold_valid_q && start) begin
            load = 1'b1;
          end else begin
            clear = 1'b1;
          end
        end else begin
          advance = start;
        end
      end
      default: ;
    endcase
  end

  // FSM state, holding register and registered frame/done outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      frame_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // load needs hold_valid_q, so capture and transfer never coincide.
      if (bus.wr && !hold_valid_q) begin
        hold_q       <= bus.datai;
        hold_valid_q <= 1'b1;
      end else if (load) begin
        hold_valid_q <= 1'b0;
      end
      done_q <= advance && penult;
      if (load) begin
        state_q <= StShift;
        frame_q <= 1'b1;
      end else if (clear) begin
        state_q <= StIdle;
        frame_q <= 1'b0;
      end
    end
  end

  pss8_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .clr     (clr),
    .load    (load),
    .advance (advance),
    .clear   (clear),
    .data    (hold_q),
    .cur_bit (cur_bit),
    .last    (last),
    .penult  (penult)
  );

  assign bus.rdy = !hold_valid_q;
  assign datao   = cur_bit;
  assign frame   = frame_q;
  assign done    = done_q;

endmodule

// File: doc/pss8.md
# pss8

Parallel-to-serial transmitter, the sending end of the 8-bit serial link terminated by `sps8`. Accepts a parallel word through a one-entry holding register and shifts it out MSB-first, one bit per clock, with a frame strobe framing each word. The holding register lets a producer queue the next word during transmission, so back-to-back words go out with no idle gap.

## Interface
- `WIDTH`, default 8: word width in bits, at least 2.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `clr`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: transmit enable. Low means no new frame starts and an in-progress frame freezes.
- `wr`, input, 1: write strobe for `datai`. Accepted only when `rdy` is 1.
- `datai`, input, WIDTH: parallel word to send.
- `rdy`, output, 1: holding register empty. Combinational `!hold_valid`.
- `datao`, output, 1: serial data, registered.
- `frame`, output, 1: high on every cycle in which `datao` carries a valid bit, registered.
- `done`, output, 1: one-cycle pulse coincident with the last bit of a word, registered.

## Operation
- Reset (`clr` = 0):
  - `datao` = 0, `frame` = 0, `done` = 0.
  - `hold_valid` = 0, so `rdy` = 1.
  - State = IDLE, bit counter = 0.
  - Reset mid-frame aborts the word with no further bits; both the queued and the shifting word are discarded.
- Holding register: on an edge with `wr` && `rdy`, capture `datai` and set `hold_valid`. `wr` while `rdy` = 0 is ignored and the held word is unchanged.
- States:
  - IDLE:
    - `frame` = 0, `datao` = 0.
    - If `hold_valid` && `start`: load the shift register from the holding register, clear `hold_valid`, set counter to 0, go to SHIFT.
  - SHIFT:
    - `frame` = 1 and `datao` = current bit.
    - With `start` = 1: each edge advances one bit. On the edge that presents bit WIDTH-1 (counter = WIDTH-1), `done` = 1 for that cycle.
    - With `start` = 0: counter, `datao`, `frame` and shift register all hold. `done` does not repeat.
  - End of word: on the edge after the last bit, if `hold_valid` && `start`, reload from the holding register and stay in SHIFT with no gap. Otherwise go to IDLE.
- `done` is a pulse per word, not per state: on a pause during the last bit it stays high for one cycle only.
- Counter width is clog2(WIDTH). It wraps only by reload to 0, never by overflow.

## Timing
- `wr` accepted at edge N. With `start` = 1 and IDLE, the transfer to the shift register happens at edge N+1. First bit, with `frame` = 1, is valid after edge N+1.
- Last bit is valid after edge N+WIDTH, with `done` = 1 in the same cycle. `frame` falls after edge N+WIDTH+1 if nothing is queued.
- `rdy` returns high in the cycle after the transfer edge. A new word is accepted at the earliest one edge after the transfer.
- Throughput is one word per WIDTH cycles sustained, with zero-cycle gaps between words.
- Simultaneous events:
  - `wr` on the same edge as the transfer: ignored, since `rdy` was 0.
  - `start` falling on the reload edge: no reload; go to IDLE with the word still held.

## Structure
- Package `pss8_pkg`:
  - state enum {IDLE, SHIFT}
  - default WIDTH constant
  - counter-width function (clog2)
- Sub-module `pss8_shift` holds the shift register and bit counter:
  - inputs: load, advance, MSB_FIRST
  - outputs: current bit, last flag
- Top level holds the holding register, FSM and output registers.

## Test plan
- Reset then single word: `wr` with `datai` = 8'h11 while `start` = 1. Required `datao` sequence 0,0,0,1,0,0,0,1 with `frame` high for exactly 8 cycles. `done` is high on the 8th bit only.
- Back-to-back: write 8'h11, then 8'hA5 while the first is shifting. Required 16 contiguous `frame` cycles, bits 00010001 10100101, and two `done` pulses 8 cycles apart.
- Back-pressure: with the holding register full, pulse `wr` with 8'hFF. It is ignored, and the queued word goes out unchanged.
- Pause: drop `start` for 3 cycles after bit 3 of 8'hC3. `datao` and `frame` hold, then the remaining bits resume; total `frame` high time is 11 cycles.
- Reset mid-frame: assert `clr` low after bit 4 of 8'h11. `datao`, `frame` and `done` go to 0 immediately and `rdy` = 1. After release, no bits are emitted until a new `wr`.
- LSB-first variant: set `MSB_FIRST` = 0 and send 8'h01. Required sequence 1,0,0,0,0,0,0,0.
